// File: rtl/delay_pulse_launcher_pkg.sv
// Shared types and constants for the delay-line launcher and its wrapper.
// Holds the FSM state encoding, default timing constants and the one-hot encoder.
package delay_pulse_launcher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PULSE  = 2'd2,
        HOLD   = 2'd3
    } dpl_state_e;

    localparam int unsigned DPL_SETTLE_CYC = 2;
    localparam int unsigned DPL_HOLD_CYC   = 4;
    localparam int unsigned DPL_MAX_N      = 256;

    // Binary index to one-hot; callers truncate the result to their tap count.
    function automatic logic [DPL_MAX_N-1:0] onehot(input int unsigned idx);
        logic [DPL_MAX_N-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        return v << idx;
    endfunction

endpackage

// File: rtl/delay_pulse_launcher_pulse_timer.sv
// Loadable down-counter with a zero flag; the launcher reloads it on every state change.
module delay_pulse_launcher_pulse_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!zero_c) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/delay_pulse_launcher.sv
// Tap-select request to one-hot code, settle, launch pulse, hold sequencer for the delay line.
// Optional tap sweep mode is enabled by defining DELAY_SWEEP_EN.
module delay_pulse_launcher
    import delay_pulse_launcher_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned TAP_W      = $clog2(N),
    parameter int unsigned WIDTH_W    = 8,
    parameter int unsigned SETTLE_CYC = DPL_SETTLE_CYC,
    parameter int unsigned HOLD_CYC   = DPL_HOLD_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TAP_W-1:0]   req_tap,
    input  logic [WIDTH_W-1:0] req_width,
`ifdef DELAY_SWEEP_EN
    input  logic               sweep_start,
    input  logic [WIDTH_W-1:0] sweep_width,
    output logic               sweep_done,
`endif
    output logic [N-1:0]       code_o,
    output logic               pulse_o,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_W = WIDTH_W;

    dpl_state_e         state;
    logic [WIDTH_W-1:0] width_r;

    logic               accept_c;
    logic               clamp_c;
    logic [TAP_W-1:0]   tap_c;
    logic [WIDTH_W-1:0] width_c;
    logic               launch_c;
    logic               tmr_load_c;
    logic [CNT_W-1:0]   tmr_val_c;
    logic               tmr_zero_c;

    assign accept_c = (state == IDLE) && req_valid && req_ready;
    assign clamp_c  = (32'(req_tap) >= N);
    assign tap_c    = clamp_c ? TAP_W'(N - 1) : req_tap;
    assign width_c  = (req_width == '0) ? WIDTH_W'(1) : req_width;

`ifdef DELAY_SWEEP_EN
    logic               sweep_active;
    logic [TAP_W-1:0]   sweep_idx;
    logic               sweep_launch_c;
    logic               sweep_last_c;
    logic [WIDTH_W-1:0] sweep_w_c;

    // A pending request takes priority over starting a sweep.
    assign sweep_launch_c = (state == IDLE) && req_ready && sweep_start && !req_valid;
    assign sweep_last_c   = (sweep_idx == TAP_W'(N - 1));
    assign sweep_w_c      = (sweep_width == '0) ? WIDTH_W'(1) : sweep_width;
    assign launch_c       = accept_c || sweep_launch_c || ((state == IDLE) && sweep_active);
`else
    assign launch_c       = accept_c;
`endif

    // Timer reload value for the state being entered.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        case (state)
            IDLE: begin
                if (launch_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = CNT_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (tmr_zero_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = width_r - CNT_W'(1);
                end
            end
            PULSE: begin
                if (tmr_zero_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = CNT_W'(HOLD_CYC - 1);
                end
            end
            default: begin
            end
        endcase
    end

    delay_pulse_launcher_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_pulse_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .zero_c   (tmr_zero_c)
    );

    // Sequencer with registered outputs; code_o only moves on a launch from IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            code_o       <= '0;
            pulse_o      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            req_ready    <= 1'b0;
            width_r      <= WIDTH_W'(1);
`ifdef DELAY_SWEEP_EN
            sweep_active <= 1'b0;
            sweep_idx    <= '0;
            sweep_done   <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
`ifdef DELAY_SWEEP_EN
            sweep_done <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    pulse_o   <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    if (accept_c) begin
                        code_o    <= N'(onehot(32'(tap_c)));
                        width_r   <= width_c;
                        state     <= SETTLE;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (clamp_c) begin
                            err <= 1'b1;
                        end
                    end
`ifdef DELAY_SWEEP_EN
                    else if (sweep_active) begin
                        sweep_idx <= sweep_idx + TAP_W'(1);
                        code_o    <= N'(onehot(32'(sweep_idx + TAP_W'(1))));
                        state     <= SETTLE;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end else if (sweep_launch_c) begin
                        sweep_active <= 1'b1;
                        sweep_idx    <= '0;
                        code_o       <= N'(onehot(0));
                        width_r      <= sweep_w_c;
                        state        <= SETTLE;
                        busy         <= 1'b1;
                        req_ready    <= 1'b0;
                    end
`endif
                end
                SETTLE: begin
                    if (tmr_zero_c) begin
                        state   <= PULSE;
                        pulse_o <= 1'b1;
                    end
                end
                PULSE: begin
                    if (tmr_zero_c) begin
                        state   <= HOLD;
                        pulse_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (tmr_zero_c) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
`ifdef DELAY_SWEEP_EN
                        if (sweep_active) begin
                            if (sweep_last_c) begin
                                sweep_active <= 1'b0;
                                sweep_done   <= 1'b1;
                            end else begin
                                req_ready <= 1'b0;
                            end
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_pulse_launcher.sv
// Self-checking bench for delay_pulse_launcher: per-cycle reference model plus a done-time scoreboard.
// Sweep scenario is included when DELAY_SWEEP_EN is defined.
module tb_delay_pulse_launcher;

    localparam int unsigned N       = 8;
    localparam int unsigned TAP_W   = 4;
    localparam int unsigned WIDTH_W = 8;
    localparam int          S       = 2;
    localparam int          H       = 3;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               req_valid = 1'b0;
    logic [TAP_W-1:0]   req_tap   = '0;
    logic [WIDTH_W-1:0] req_width = '0;
    logic               req_ready;
    logic [N-1:0]       code_o;
    logic               pulse_o;
    logic               busy;
    logic               done;
    logic               err;
`ifdef DELAY_SWEEP_EN
    logic               sweep_start = 1'b0;
    logic [WIDTH_W-1:0] sweep_width = '0;
    logic               sweep_done;
`endif

    always #5 clk = ~clk;

    delay_pulse_launcher #(
        .N          (N),
        .TAP_W      (TAP_W),
        .WIDTH_W    (WIDTH_W),
        .SETTLE_CYC (S),
        .HOLD_CYC   (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tap     (req_tap),
        .req_width   (req_width),
`ifdef DELAY_SWEEP_EN
        .sweep_start (sweep_start),
        .sweep_width (sweep_width),
        .sweep_done  (sweep_done),
`endif
        .code_o      (code_o),
        .pulse_o     (pulse_o),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [N-1:0] code;
        logic         err;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;

    // Reference model state: cycles remaining until ready returns
    logic         m_rdy  = 1'b0;
    logic         m_err  = 1'b0;
    logic         m_done = 1'b0;
    logic [N-1:0] m_code = '0;
    int           m_left = 0;
    int           m_w    = 1;
    bit           chk_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from the driven inputs, then compare all outputs 1 time unit later.
    task automatic tick();
        logic acc;
        int   tc;
        exp_t e;
        acc = rst_n && req_valid && m_rdy;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_rdy  = 1'b0;
            m_err  = 1'b0;
            m_done = 1'b0;
            m_code = '0;
            m_left = 0;
            sb_q.delete();
        end else begin
            m_done = (m_left == 1);
            if (m_left > 0) m_left--;
            if (acc) begin
                tc     = (32'(req_tap) >= N) ? int'(N) - 1 : int'(req_tap);
                m_code = N'(1) << tc;
                if (32'(req_tap) >= N) m_err = 1'b1;
                m_w    = (req_width == '0) ? 1 : int'(req_width);
                m_left = S + m_w + H;
                e.code = m_code;
                e.err  = m_err;
                sb_q.push_back(e);
            end
            m_rdy = (m_left == 0);
        end
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(m_rdy));
            chk("busy",      32'(busy),      32'(m_left > 0));
            chk("code_o",    32'(code_o),    32'(m_code));
            chk("err",       32'(err),       32'(m_err));
            chk("pulse_o",   32'(pulse_o),   32'((m_left >= H + 1) && (m_left <= m_w + H)));
            chk("done",      32'(done),      32'(m_done));
            if (done) begin
                chk("sb_pending", 32'(sb_q.size() > 0), 32'(1));
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_code", 32'(code_o), 32'(e.code));
                    chk("sb_err",  32'(err),    32'(e.err));
                end
            end
        end
    endtask

    task automatic send(input int tap, input int width);
        req_tap   = TAP_W'(tap);
        req_width = WIDTH_W'(width);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        idle(2);
        chk("rst_code",  32'(code_o),    32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(req_ready), 32'(1));

        // Single request: tap 5, width 3
        send(5, 3);
        chk("single_code", 32'(code_o), 32'h20);
        idle(10);

        // Zero width behaves as one cycle
        send(2, 0);
        idle(8);

        // Out of range clamps to the top tap and sets sticky err
        send(9, 4);
        chk("oor_code", 32'(code_o), 32'h80);
        chk("oor_err",  32'(err),    32'(1));
        idle(11);
        send(3, 1);
        idle(8);
        chk("err_sticky", 32'(err), 32'(1));

        // Maximum width
        send(0, 255);
        idle(262);

        // Inputs churn while busy; second request lands in the done cycle
        req_tap   = 4'd1;
        req_width = 8'd2;
        req_valid = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            req_valid = (i % 2) == 0;
            req_tap   = TAP_W'($urandom_range(0, 15));
            req_width = WIDTH_W'($urandom_range(0, 255));
            tick();
        end
        req_valid = 1'b1;
        req_tap   = 4'd6;
        req_width = 8'd1;
        tick();
        chk("b2b_done", 32'(done), 32'(1));
        tick();
        req_valid = 1'b0;
        chk("b2b_code", 32'(code_o), 32'h40);
        idle(9);

        // Reset while the pulse is high
        send(4, 5);
        idle(2);
        chk("mid_pulse_high", 32'(pulse_o), 32'(1));
        rst_n = 1'b0;
        tick();
        chk("rst_pulse", 32'(pulse_o), 32'(0));
        chk("rst_busy",  32'(busy),    32'(0));
        rst_n = 1'b1;
        idle(12);

        // Same single request after recovery
        send(5, 3);
        chk("recover_code", 32'(code_o), 32'h20);
        idle(10);

`ifdef DELAY_SWEEP_EN
        begin
            int           n_pulse;
            int           n_done;
            int           last_start;
            int           cyc;
            logic         prev_pulse;
            logic [N-1:0] exp_code;
            chk_en      = 1'b0;
            sweep_width = 8'd1;
            sweep_start = 1'b1;
            tick();
            sweep_start = 1'b0;
            n_pulse     = 0;
            n_done      = 0;
            last_start  = 0;
            prev_pulse  = 1'b0;
            for (cyc = 1; cyc <= 70; cyc++) begin
                if (pulse_o && !prev_pulse) begin
                    exp_code = N'(1) << n_pulse;
                    chk("sweep_code", 32'(code_o), 32'(exp_code));
                    if (n_pulse > 0) chk("sweep_spacing", 32'(cyc - last_start), 32'(7));
                    last_start = cyc;
                    n_pulse++;
                end
                if (done) begin
                    n_done++;
                    chk("sweep_done_at", 32'(sweep_done), 32'(n_done == 8));
                end else begin
                    chk("sweep_done_idle", 32'(sweep_done), 32'(0));
                end
                prev_pulse = pulse_o;
                tick();
            end
            chk("sweep_pulses", 32'(n_pulse), 32'(8));
            chk("sweep_dones",  32'(n_done),  32'(8));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
